// File: rtl/r_uid_allocator.sv
// rtl/r_uid_allocator.sv - maps original AR IDs onto {row,col} uids and restores them for R responses
module r_uid_allocator #(
    parameter  int ID_WIDTH = 32,
    parameter  int NUM_ROWS = 16,
    parameter  int NUM_COLS = 16,
    localparam int ROW_W    = $clog2(NUM_ROWS),
    localparam int COL_W    = $clog2(NUM_COLS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_valid,
    output logic                alloc_ready,
    input  logic [ID_WIDTH-1:0] alloc_orig_id,
    output logic [ID_WIDTH-1:0] alloc_uid,
    input  logic                free_req,
    input  logic [ID_WIDTH-1:0] free_uid,
    input  logic [ID_WIDTH-1:0] restore_uid,
    output logic [ID_WIDTH-1:0] restored_id,
    output logic                free_err,
    output logic [ROW_W:0]      rows_in_use
);
    localparam int UID_W = ROW_W + COL_W;
    localparam int CNT_W = $clog2(NUM_COLS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_COLS);

    logic [ID_WIDTH-1:0] bound_id  [NUM_ROWS];
    logic [COL_W-1:0]    alloc_ptr [NUM_ROWS];
    logic [CNT_W-1:0]    count     [NUM_ROWS];

    logic             hit;
    logic             any_free;
    logic [ROW_W-1:0] hit_row;
    logic [ROW_W-1:0] free_row;
    logic [ROW_W-1:0] target_row;
    logic             alloc_fire;

    // Descending scan so the lowest-index free row wins.
    always_comb begin
        hit      = 1'b0;
        hit_row  = '0;
        any_free = 1'b0;
        free_row = '0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (count[r] != '0 && bound_id[r] == alloc_orig_id) begin
                hit     = 1'b1;
                hit_row = ROW_W'(r);
            end
            if (count[r] == '0) begin
                any_free = 1'b1;
                free_row = ROW_W'(r);
            end
        end
    end

    assign target_row  = hit ? hit_row : free_row;
    assign alloc_ready = hit ? (count[hit_row] < CNT_FULL) : any_free;
    assign alloc_uid   = ID_WIDTH'({target_row, alloc_ptr[target_row]});
    assign alloc_fire  = alloc_valid & alloc_ready;

    logic [ROW_W-1:0] fr;
    logic [COL_W-1:0] fc;
    logic [COL_W-1:0] oldest_col;
    logic             free_ok;
    logic             free_fire;

    // A full row has count == NUM_COLS, whose low bits are 0, so the oldest column is alloc_ptr itself.
    assign fr         = free_uid[UID_W-1:COL_W];
    assign fc         = free_uid[COL_W-1:0];
    assign oldest_col = alloc_ptr[fr] - count[fr][COL_W-1:0];
    assign free_ok    = (count[fr] != '0) && (fc == oldest_col);
    assign free_fire  = free_req & free_ok;

    assign restored_id = bound_id[restore_uid[UID_W-1:COL_W]];

    logic unused_uid_bits;
    assign unused_uid_bits = ^{free_uid[ID_WIDTH-1:UID_W], restore_uid[ID_WIDTH-1:UID_W]};

    logic [CNT_W-1:0] count_nxt [NUM_ROWS];
    logic [ROW_W:0]   rows_nxt;

    always_comb begin
        rows_nxt = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            count_nxt[r] = count[r];
            if (alloc_fire && target_row == ROW_W'(r) && !(free_fire && fr == ROW_W'(r)))
                count_nxt[r] = count[r] + CNT_W'(1);
            else if (free_fire && fr == ROW_W'(r) && !(alloc_fire && target_row == ROW_W'(r)))
                count_nxt[r] = count[r] - CNT_W'(1);
            if (count_nxt[r] != '0)
                rows_nxt = rows_nxt + (ROW_W + 1)'(1);
        end
    end

    // alloc_ptr survives row release so it stays aligned with the ordering unit's release index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                bound_id[r]  <= '0;
                alloc_ptr[r] <= '0;
                count[r]     <= '0;
            end
            rows_in_use <= '0;
            free_err    <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_ROWS; r++)
                count[r] <= count_nxt[r];
            if (alloc_fire) begin
                alloc_ptr[target_row] <= alloc_ptr[target_row] + COL_W'(1);
                if (!hit)
                    bound_id[target_row] <= alloc_orig_id;
            end
            rows_in_use <= rows_nxt;
            free_err    <= free_req & ~free_ok;
        end
    end
endmodule
